// File: rtl/iterative_alu.sv
// Registered ALU with start/done handshake; mult/div iterate one bit per cycle.
// Optional signed-overflow output is enabled by defining ITERATIVE_ALU_OVERFLOW_EN.
module iterative_alu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             div_by_zero
`ifdef ITERATIVE_ALU_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

  localparam logic [SHW-1:0] LastIter = SHW'(WIDTH - 1);

  state_e           state;
  logic [SHW-1:0]   count;
  logic [WIDTH-1:0] operand;  // multiplicand or divisor magnitude
  logic [WIDTH-1:0] acc;      // upper product half or partial remainder
  logic [WIDTH-1:0] shreg;    // multiplier bits / dividend-into-quotient bits
  logic             neg_lo;   // negate product / quotient at the end
  logic             neg_hi;   // negate remainder at the end

  logic             is_signed;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_out;

  always_comb begin
    is_signed = ~op[0];
    a_mag     = (is_signed && a[WIDTH-1]) ? -a : a;
    b_mag     = (is_signed && b[WIDTH-1]) ? -b : b;
    shamt     = b[SHW-1:0];
  end

  always_comb begin
    alu_out = '0;
    case (op)
      4'd0:    alu_out = a & b;
      4'd1:    alu_out = a | b;
      4'd2:    alu_out = a + b;
      4'd3:    alu_out = {{(WIDTH-1){1'b0}}, (a < b)};
      4'd4:    alu_out = a ^ b;
      4'd5:    alu_out = ~(a | b);
      4'd6:    alu_out = a - b;
      4'd7:    alu_out = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'd12:   alu_out = a << shamt;
      4'd13:   alu_out = a >> shamt;
      4'd14:   alu_out = $unsigned($signed(a) >>> shamt);
      default: alu_out = '0;
    endcase
  end

`ifdef ITERATIVE_ALU_OVERFLOW_EN
  logic [WIDTH-1:0] ovf_sum;
  logic [WIDTH-1:0] ovf_diff;
  logic             alu_ovf;

  always_comb begin
    ovf_sum  = a + b;
    ovf_diff = a - b;
    alu_ovf  = 1'b0;
    if (op == 4'd2) begin
      alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (ovf_sum[WIDTH-1] != a[WIDTH-1]);
    end else if (op == 4'd6) begin
      alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (ovf_diff[WIDTH-1] != a[WIDTH-1]);
    end
  end
`endif

  // Shift-add step: conditionally add multiplicand, then shift {acc,shreg} right.
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_acc_nxt;
  logic [WIDTH-1:0]   mul_sh_nxt;
  logic [2*WIDTH-1:0] mul_full;
  logic [2*WIDTH-1:0] mul_fin;

  always_comb begin
    mul_sum     = {1'b0, acc} + (shreg[0] ? {1'b0, operand} : '0);
    mul_acc_nxt = mul_sum[WIDTH:1];
    mul_sh_nxt  = {mul_sum[0], shreg[WIDTH-1:1]};
    mul_full    = {mul_acc_nxt, mul_sh_nxt};
    mul_fin     = neg_lo ? -mul_full : mul_full;
  end

  // Restoring division step; a set top bit of the difference means a borrow.
  logic [WIDTH:0]   div_rs;
  logic [WIDTH:0]   div_diff;
  logic             div_ok;
  logic [WIDTH-1:0] div_rem_nxt;
  logic [WIDTH-1:0] div_quo_nxt;
  logic [WIDTH-1:0] quo_fin;
  logic [WIDTH-1:0] rem_fin;

  always_comb begin
    div_rs      = {acc, shreg[WIDTH-1]};
    div_diff    = div_rs - {1'b0, operand};
    div_ok      = ~div_diff[WIDTH];
    div_rem_nxt = div_ok ? div_diff[WIDTH-1:0] : div_rs[WIDTH-1:0];
    div_quo_nxt = {shreg[WIDTH-2:0], div_ok};
    quo_fin     = neg_lo ? -div_quo_nxt : div_quo_nxt;
    rem_fin     = neg_hi ? -div_rem_nxt : div_rem_nxt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= StIdle;
      count       <= '0;
      operand     <= '0;
      acc         <= '0;
      shreg       <= '0;
      neg_lo      <= 1'b0;
      neg_hi      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      hi          <= '0;
      zero        <= 1'b1;
      div_by_zero <= 1'b0;
`ifdef ITERATIVE_ALU_OVERFLOW_EN
      overflow    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        StIdle: begin
          if (start) begin
            if (op[3:2] == 2'b10 && !op[1]) begin
              operand <= a_mag;
              shreg   <= b_mag;
              acc     <= '0;
              neg_lo  <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_hi  <= 1'b0;
              count   <= '0;
              busy    <= 1'b1;
              state   <= StMul;
            end else if (op[3:2] == 2'b10 && b == '0) begin
              done        <= 1'b1;
              result      <= '1;
              hi          <= a;
              zero        <= 1'b0;
              div_by_zero <= 1'b1;
`ifdef ITERATIVE_ALU_OVERFLOW_EN
              overflow    <= 1'b0;
`endif
            end else if (op[3:2] == 2'b10) begin
              operand <= b_mag;
              shreg   <= a_mag;
              acc     <= '0;
              neg_lo  <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_hi  <= is_signed & a[WIDTH-1];
              count   <= '0;
              busy    <= 1'b1;
              state   <= StDiv;
            end else begin
              done   <= 1'b1;
              result <= alu_out;
              zero   <= (alu_out == '0);
`ifdef ITERATIVE_ALU_OVERFLOW_EN
              overflow <= alu_ovf;
`endif
            end
          end
        end
        StMul: begin
          count <= count + SHW'(1);
          acc   <= mul_acc_nxt;
          shreg <= mul_sh_nxt;
          if (count == LastIter) begin
            state         <= StIdle;
            busy          <= 1'b0;
            done          <= 1'b1;
            {hi, result}  <= mul_fin;
            zero          <= (mul_fin[WIDTH-1:0] == '0);
`ifdef ITERATIVE_ALU_OVERFLOW_EN
            overflow      <= 1'b0;
`endif
          end
        end
        StDiv: begin
          count <= count + SHW'(1);
          acc   <= div_rem_nxt;
          shreg <= div_quo_nxt;
          if (count == LastIter) begin
            state       <= StIdle;
            busy        <= 1'b0;
            done        <= 1'b1;
            result      <= quo_fin;
            hi          <= rem_fin;
            zero        <= (quo_fin == '0);
            div_by_zero <= 1'b0;
`ifdef ITERATIVE_ALU_OVERFLOW_EN
            overflow    <= 1'b0;
`endif
          end
        end
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_alu.sv
// Directed self-checking bench for iterative_alu at WIDTH=32.
module tb_iterative_alu;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [W-1:0] hi;
  logic         zero;
  logic         div_by_zero;
`ifdef ITERATIVE_ALU_OVERFLOW_EN
  logic         overflow;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  vec_t sc_vec [14];

  iterative_alu #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .hi          (hi),
    .zero        (zero),
    .div_by_zero (div_by_zero)
`ifdef ITERATIVE_ALU_OVERFLOW_EN
    ,
    .overflow    (overflow)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // Returns at the falling edge just after the accepting edge (cycle 1).
  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clock);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(negedge clock);
    start = 1'b0;
    op    = 4'd5;
    a     = 32'hDEAD_BEEF;
    b     = 32'h0BAD_F00D;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < 200) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(negedge clock);
    checks++;
    if ({busy, done, zero, div_by_zero} !== 4'b0010) begin
      errors++;
      $display("FAIL reset_flags: got busy/done/zero/dbz=%b, expected 0010",
               {busy, done, zero, div_by_zero});
    end
    checks++;
    if ({hi, result} !== 64'h0) begin
      errors++;
      $display("FAIL reset_data: got hi:result=%h, expected 0", {hi, result});
    end
`ifdef ITERATIVE_ALU_OVERFLOW_EN
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_overflow: got %b, expected 0", overflow);
    end
`endif
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL idle_after_reset: got busy/done=%b, expected 00", {busy, done});
    end
  endtask

  task automatic test_mult;
    int cyc;
    int busy_bad;
    issue(4'd8, 32'hFFFF_FFFD, 32'd5);
    cyc = 1;
    busy_bad = 0;
    while (done !== 1'b1 && cyc < 200) begin
      if (busy !== 1'b1) busy_bad++;
      if (cyc == 10) begin
        start = 1'b1; op = 4'd2; a = 32'd1; b = 32'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
      cyc++;
    end
    start = 1'b0;
    checks++;
    if (cyc != 33) begin
      errors++;
      $display("FAIL mult_latency: got done in cycle %0d, expected 33", cyc);
    end
    checks++;
    if (busy_bad != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mult_busy: got %0d low-busy cycles, busy at done=%b, expected 0 and 0",
               busy_bad, busy);
    end
    checks++;
    if ({hi, result, zero} !== {32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0}) begin
      errors++;
      $display("FAIL mult_signed: got hi=%h result=%h zero=%b, expected ffffffff fffffff1 0",
               hi, result, zero);
    end
    @(negedge clock);
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL mult_single_done: got busy/done=%b, expected 00", {busy, done});
    end
  endtask

  task automatic test_add_hi_hold;
    issue(4'd2, 32'h0000_0005, 32'hFFFF_FFFB);
    checks++;
    if ({done, busy, zero, result} !== {1'b1, 1'b0, 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL add_wrap: got done=%b busy=%b zero=%b result=%h, expected 1 0 1 0",
               done, busy, zero, result);
    end
    checks++;
    if (hi !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL add_hi_hold: got hi=%h, expected ffffffff", hi);
    end
    @(negedge clock);
    checks++;
    if ({busy, done, result} !== {2'b00, 32'h0}) begin
      errors++;
      $display("FAIL add_after: got busy/done=%b result=%h, expected 00 0",
               {busy, done}, result);
    end
  endtask

  task automatic test_single_cycle;
    sc_vec = '{
      '{4'd7,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001},
      '{4'd3,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000},
      '{4'd14, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000},
      '{4'd7,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000},
      '{4'd3,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001},
      '{4'd0,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000},
      '{4'd1,  32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0},
      '{4'd4,  32'hFFFF_0000, 32'hF0F0_F0F0, 32'h0F0F_F0F0},
      '{4'd5,  32'hF0F0_F0F0, 32'h0F0F_0000, 32'h0000_0F0F},
      '{4'd6,  32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE},
      '{4'd12, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000},
      '{4'd13, 32'h8000_0000, 32'h0000_003F, 32'h0000_0001},
      '{4'd15, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000},
      '{4'd2,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE}
    };
    for (int i = 0; i < 14; i++) begin
      issue(sc_vec[i].op, sc_vec[i].a, sc_vec[i].b);
      checks++;
      if ({done, busy, zero, result} !== {1'b1, 1'b0, (sc_vec[i].exp == 0), sc_vec[i].exp}) begin
        errors++;
        $display("FAIL single_op%0d: got done=%b busy=%b zero=%b result=%h, expected 1 0 %b %h",
                 sc_vec[i].op, done, busy, zero, result, (sc_vec[i].exp == 0), sc_vec[i].exp);
      end
    end
    checks++;
    if (hi !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL single_hi_hold: got hi=%h, expected ffffffff", hi);
    end
  endtask

  task automatic test_div;
    int cyc;
    issue(4'd10, 32'hFFFF_FFF9, 32'd2);
    wait_done(cyc);
    checks++;
    if (cyc != 33) begin
      errors++;
      $display("FAIL div_latency: got done in cycle %0d, expected 33", cyc);
    end
    checks++;
    if ({result, hi, div_by_zero} !== {32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0}) begin
      errors++;
      $display("FAIL div_signed: got result=%h hi=%h dbz=%b, expected fffffffd ffffffff 0",
               result, hi, div_by_zero);
    end
    issue(4'd10, 32'd7, 32'hFFFF_FFFE);
    wait_done(cyc);
    checks++;
    if ({result, hi} !== {32'hFFFF_FFFD, 32'h0000_0001}) begin
      errors++;
      $display("FAIL div_neg_divisor: got result=%h hi=%h, expected fffffffd 00000001",
               result, hi);
    end
    issue(4'd11, 32'd7, 32'd0);
    checks++;
    if ({done, busy, zero, div_by_zero, result, hi} !==
        {4'b1001, 32'hFFFF_FFFF, 32'h0000_0007}) begin
      errors++;
      $display("FAIL div_by_zero: got done=%b busy=%b zero=%b dbz=%b result=%h hi=%h, expected 1 0 0 1 ffffffff 00000007",
               done, busy, zero, div_by_zero, result, hi);
    end
    issue(4'd0, 32'hFFFF_FFFF, 32'h0000_00FF);
    checks++;
    if ({div_by_zero, hi, result} !== {1'b1, 32'h0000_0007, 32'h0000_00FF}) begin
      errors++;
      $display("FAIL dbz_hold: got dbz=%b hi=%h result=%h, expected 1 00000007 000000ff",
               div_by_zero, hi, result);
    end
    issue(4'd11, 32'd100, 32'd7);
    wait_done(cyc);
    checks++;
    if ({result, hi, div_by_zero} !== {32'd14, 32'd2, 1'b0}) begin
      errors++;
      $display("FAIL divu: got result=%h hi=%h dbz=%b, expected 0000000e 00000002 0",
               result, hi, div_by_zero);
    end
    issue(4'd10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(cyc);
    checks++;
    if ({result, hi, div_by_zero} !== {32'h8000_0000, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL div_min_neg1: got result=%h hi=%h dbz=%b, expected 80000000 00000000 0",
               result, hi, div_by_zero);
    end
    issue(4'd10, 32'h1234, 32'd0);
    checks++;
    if ({done, div_by_zero, hi} !== {2'b11, 32'h0000_1234}) begin
      errors++;
      $display("FAIL div_by_zero_signed: got done=%b dbz=%b hi=%h, expected 1 1 00001234",
               done, div_by_zero, hi);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    issue(4'd9, 32'h0001_0000, 32'h0001_0000);
    wait_done(cyc);
    checks++;
    if ({cyc == 33, zero, hi, result} !== {2'b11, 32'h1, 32'h0}) begin
      errors++;
      $display("FAIL multu_zero: got cycle=%0d zero=%b hi=%h result=%h, expected 33 1 00000001 0",
               cyc, zero, hi, result);
    end
    start = 1'b1; op = 4'd0; a = 32'hFF00_FF00; b = 32'h0FF0_0FF0;
    @(negedge clock);
    start = 1'b0;
    checks++;
    if ({done, busy, zero, result, hi} !== {3'b100, 32'h0F00_0F00, 32'h1}) begin
      errors++;
      $display("FAIL back_to_back: got done=%b busy=%b zero=%b result=%h hi=%h, expected 1 0 0 0f000f00 00000001",
               done, busy, zero, result, hi);
    end
    @(negedge clock);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back_pulse: got done=%b, expected 0", done);
    end
  endtask

  task automatic test_reset_mid_op;
    int pulses;
    issue(4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int c = 1; c < 10; c++) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({busy, done, zero, div_by_zero, result, hi} !== {4'b0010, 64'h0}) begin
      errors++;
      $display("FAIL reset_mid_op: got busy=%b done=%b zero=%b dbz=%b result=%h hi=%h, expected 0 0 1 0 0 0",
               busy, done, zero, div_by_zero, result, hi);
    end
    reset = 1'b0;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL reset_abort: got %0d busy/done cycles after reset, expected 0", pulses);
    end
    issue(4'd1, 32'h0000_00F0, 32'h0000_000F);
    checks++;
    if ({done, result, hi} !== {1'b1, 32'h0000_00FF, 32'h0}) begin
      errors++;
      $display("FAIL after_reset_op: got done=%b result=%h hi=%h, expected 1 000000ff 0",
               done, result, hi);
    end
  endtask

`ifdef ITERATIVE_ALU_OVERFLOW_EN
  task automatic test_overflow;
    issue(4'd2, 32'h7FFF_FFFF, 32'd1);
    checks++;
    if ({overflow, result} !== {1'b1, 32'h8000_0000}) begin
      errors++;
      $display("FAIL ovf_add: got overflow=%b result=%h, expected 1 80000000", overflow, result);
    end
    issue(4'd6, 32'h8000_0000, 32'd1);
    checks++;
    if ({overflow, result} !== {1'b1, 32'h7FFF_FFFF}) begin
      errors++;
      $display("FAIL ovf_sub: got overflow=%b result=%h, expected 1 7fffffff", overflow, result);
    end
    issue(4'd2, 32'd1, 32'd1);
    checks++;
    if ({overflow, result} !== {1'b0, 32'd2}) begin
      errors++;
      $display("FAIL ovf_add_clear: got overflow=%b result=%h, expected 0 00000002",
               overflow, result);
    end
    issue(4'd6, 32'd0, 32'd1);
    checks++;
    if ({overflow, result} !== {1'b0, 32'hFFFF_FFFF}) begin
      errors++;
      $display("FAIL ovf_sub_clear: got overflow=%b result=%h, expected 0 ffffffff",
               overflow, result);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_mult();
    test_add_hi_hold();
    test_single_cycle();
    test_div();
    test_back_to_back();
    test_reset_mid_op();
`ifdef ITERATIVE_ALU_OVERFLOW_EN
    test_overflow();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
